// File: rtl/cache_pkg.sv
// Shared widths, access-width field positions and lane helpers for cache_nway.
// Latency: combinational helpers only.
// Backpressure: none; pure functions and constants.
package cache_pkg;

  // Bit positions inside the RV32I-style u_b_h_w access field
  localparam int UBHW_HALF     = 0;
  localparam int UBHW_WORD     = 1;
  localparam int UBHW_UNSIGNED = 2;

  function automatic int index_bits_f(input int sets);
    return $clog2(sets);
  endfunction

  // Zero when a line holds a single word
  function automatic int word_bits_f(input int block_words);
    return (block_words > 1) ? $clog2(block_words) : 0;
  endfunction

  function automatic int tag_bits_f(input int addr_bits, input int sets, input int block_words);
    return addr_bits - 2 - word_bits_f(block_words) - index_bits_f(sets);
  endfunction

  // Pull the addressed word/half/byte out of a stored word and extend it
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  bo,
                                               input logic [2:0]  f);
    logic [31:0] sh;
    logic [31:0] r;
    sh = '0;
    r  = w;
    if (!f[UBHW_WORD]) begin
      if (f[UBHW_HALF]) begin
        sh = w >> {bo[1], 4'b0000};
        r  = f[UBHW_UNSIGNED] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end else begin
        sh = w >> {bo, 3'b000};
        r  = f[UBHW_UNSIGNED] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
    end
    return r;
  endfunction

  // Merge write data into the addressed byte lanes of an existing word
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] din,
                                              input logic [1:0]  bo,
                                              input logic [2:0]  f);
    logic [31:0] mask;
    logic [31:0] data;
    if (f[UBHW_WORD]) begin
      mask = '1;
      data = din;
    end else if (f[UBHW_HALF]) begin
      mask = 32'h0000_FFFF << {bo[1], 4'b0000};
      data = {16'b0, din[15:0]} << {bo[1], 4'b0000};
    end else begin
      mask = 32'h0000_00FF << {bo, 3'b000};
      data = {24'b0, din[7:0]} << {bo, 3'b000};
    end
    return (old & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/cache_nway_if.sv
// Command/response bundle between the cache-management FSM and the cache array.
// Latency: n/a (wires only); responses are registered inside the array.
// Backpressure: none; the array accepts one command every cycle.
// master = FSM side (drives addr/commands/din), slave = cache array side.
interface cache_nway_if #(
  parameter int ADDR_BITS = 32,
  parameter int TAG_BITS  = 23,
  parameter int WAY_BITS  = 2
);
  logic [ADDR_BITS-1:0] addr;
  logic                 load;
  logic                 store;
  logic                 edit;
  logic                 invalid;
  logic [2:0]           u_b_h_w;
  logic [31:0]          din;
  logic                 hit;
  logic [31:0]          dout;
  logic                 valid;
  logic                 dirty;
  logic [TAG_BITS-1:0]  tag;
  logic [WAY_BITS-1:0]  victim_way;

  modport master (
    output addr, load, store, edit, invalid, u_b_h_w, din,
    input  hit, dout, valid, dirty, tag, victim_way
  );

  modport slave (
    input  addr, load, store, edit, invalid, u_b_h_w, din,
    output hit, dout, valid, dirty, tag, victim_way
  );
endinterface

// File: rtl/cache_lru_set.sv
// True-LRU age update and victim selection for one set's age vector.
// Latency: combinational.
// Backpressure: none.
// Ports: ages/valid of the set in, touch request in; victim and next ages out.
module cache_lru_set #(
  parameter int WAYS = 4,
  parameter int WB   = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][WB-1:0] ages,
  input  logic [WAYS-1:0]         valid,
  input  logic                    touch_en,
  input  logic [WB-1:0]           touch_way,
  output logic [WB-1:0]           victim,
  output logic [WAYS-1:0][WB-1:0] ages_nxt
);

  logic          found;
  logic [WB-1:0] touch_age;

  // Lowest invalid way first; otherwise the oldest (age WAYS-1)
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found) begin
        victim = WB'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[w] == WB'(WAYS - 1)) victim = WB'(w);
      end
    end
  end

  // Ways younger than the touched one age by one; the touched way becomes 0,
  // which keeps the vector a permutation of 0..WAYS-1.
  always_comb begin
    touch_age = ages[touch_way];
    for (int w = 0; w < WAYS; w++) begin
      ages_nxt[w] = ages[w];
      if (touch_en) begin
        if (WB'(w) == touch_way)     ages_nxt[w] = '0;
        else if (ages[w] < touch_age) ages_nxt[w] = ages[w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative data/tag/state array with true-LRU and latched refill victim.
// Latency: one cycle; outputs reflect array state before the sampling edge.
// Backpressure: none; one command per cycle, priority invalid > store > edit > load.
// Ports: clk, rst (async, active high), bus (cache_nway_if.slave: addr, commands,
// u_b_h_w, din in; hit, dout, valid, dirty, tag, victim_way out).
module cache_nway
  import cache_pkg::*;
#(
  parameter int WAYS        = 4,
  parameter int SETS        = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_BITS   = 32
) (
  input logic         clk,
  input logic         rst,
  cache_nway_if.slave bus
);

  localparam int WB    = $clog2(WAYS);
  localparam int IDX_B = index_bits_f(SETS);
  localparam int OFF_B = word_bits_f(BLOCK_WORDS);
  localparam int OFF_W = (OFF_B > 0) ? OFF_B : 1;
  localparam int TAG_B = tag_bits_f(ADDR_BITS, SETS, BLOCK_WORDS);

  logic [31:0]            data_q  [WAYS][SETS][BLOCK_WORDS];
  logic [TAG_B-1:0]       tag_q   [WAYS][SETS];
  logic [WAYS-1:0]        valid_q [SETS];
  logic [WAYS-1:0]        dirty_q [SETS];
  logic [WAYS-1:0][WB-1:0] age_q  [SETS];
  logic [WB-1:0]          fill_way_q;

  logic [IDX_B-1:0]        idx;
  logic [OFF_W-1:0]        off;
  logic [TAG_B-1:0]        atag;
  logic                    off_zero;
  logic                    hit_any;
  logic [WB-1:0]           hit_way;
  logic [WB-1:0]           victim;
  logic [WB-1:0]           sel_way;
  logic [WB-1:0]           wr_way;
  logic                    cmd_inv, cmd_store, cmd_edit, cmd_load;
  logic                    touch_en;
  logic [WB-1:0]           touch_way;
  logic [WAYS-1:0][WB-1:0] ages_nxt;

  assign idx      = bus.addr[2+OFF_B +: IDX_B];
  assign off      = (OFF_B > 0) ? bus.addr[2 +: OFF_W] : '0;
  assign atag     = bus.addr[ADDR_BITS-1 -: TAG_B];
  assign off_zero = (off == '0);

  assign cmd_inv   = bus.invalid;
  assign cmd_store = bus.store & ~bus.invalid;
  assign cmd_edit  = bus.edit  & ~bus.invalid & ~bus.store;
  assign cmd_load  = bus.load  & ~bus.invalid & ~bus.store & ~bus.edit;

  // Lowest matching way wins; more than one match cannot occur in normal use
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[w][idx] == atag)) begin
        hit_any = 1'b1;
        hit_way = WB'(w);
      end
    end
  end

  // A refill starts at offset 0, which claims the victim; later words of the
  // block go to the way latched at that point.
  assign touch_en  = ((cmd_load | cmd_edit) & hit_any) | (cmd_store & off_zero);
  assign touch_way = cmd_store ? victim : hit_way;
  assign sel_way   = hit_any ? hit_way : victim;
  assign wr_way    = cmd_store ? (off_zero ? victim : fill_way_q) : hit_way;

  cache_lru_set #(.WAYS(WAYS), .WB(WB)) u_lru (
    .ages      (age_q[idx]),
    .valid     (valid_q[idx]),
    .touch_en  (touch_en),
    .touch_way (touch_way),
    .victim    (victim),
    .ages_nxt  (ages_nxt)
  );

  // State bits, ages and the fill pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WB'(w);
      end
      fill_way_q <= '0;
    end else if (cmd_inv) begin
      valid_q[idx] <= '0;
      dirty_q[idx] <= '0;
      for (int w = 0; w < WAYS; w++) age_q[idx][w] <= WB'(w);
    end else begin
      if (touch_en) age_q[idx] <= ages_nxt;
      if (cmd_store && off_zero) begin
        fill_way_q             <= victim;
        valid_q[idx][victim]   <= 1'b1;
        dirty_q[idx][victim]   <= 1'b0;
      end
      if (cmd_edit && hit_any) dirty_q[idx][hit_way] <= 1'b1;
    end
  end

  // Data and tag storage carry no reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (cmd_store) begin
        data_q[wr_way][idx][off] <= bus.din;
        if (off_zero) tag_q[victim][idx] <= atag;
      end else if (cmd_edit && hit_any) begin
        data_q[hit_way][idx][off] <= store_merge(data_q[hit_way][idx][off], bus.din,
                                                 bus.addr[1:0], bus.u_b_h_w);
      end
    end
  end

  // Registered status; with no load acting, dout carries the victim word so
  // the FSM can stream a writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hit        <= 1'b0;
      bus.dout       <= '0;
      bus.valid      <= 1'b0;
      bus.dirty      <= 1'b0;
      bus.tag        <= '0;
      bus.victim_way <= '0;
    end else begin
      bus.hit        <= hit_any;
      bus.valid      <= valid_q[idx][sel_way];
      bus.dirty      <= dirty_q[idx][sel_way];
      bus.tag        <= tag_q[sel_way][idx];
      bus.victim_way <= victim;
      if (cmd_load) begin
        if (hit_any) bus.dout <= load_extract(data_q[hit_way][idx][off], bus.addr[1:0], bus.u_b_h_w);
      end else begin
        bus.dout <= data_q[victim][idx][off];
      end
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
module tb_cache_nway;
  localparam int W  = 4;
  localparam int S  = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_nway_if #(.ADDR_BITS(32), .TAG_BITS(23), .WAY_BITS(2)) bus();

  cache_nway #(.WAYS(W), .SETS(S), .BLOCK_WORDS(BW), .ADDR_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: recency list per set (index 0 = most recent)
  bit          m_valid  [S][W];
  bit          m_dirty  [S][W];
  bit          m_tknown [S][W];
  logic [22:0] m_tag    [S][W];
  logic [31:0] m_data   [S][W][BW];
  bit          m_dknown [S][W][BW];
  int          m_order  [S][W];
  int          m_fill;
  logic [31:0] e_dout;
  bit          e_dknown;

  logic [2:0] ftab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_order[s][w] = w;
      end
    m_fill   = 0;
    e_dout   = '0;
    e_dknown = 1;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int pos = 0;
    for (int i = 0; i < W; i++) if (m_order[s][i] == w) pos = i;
    for (int i = pos; i > 0; i--) m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < W; w++) if (!m_valid[s][w]) return w;
    return m_order[s][W-1];
  endfunction

  function automatic int m_hitway(input logic [31:0] a);
    int s = int'(a[8:4]);
    for (int w = 0; w < W; w++) if (m_valid[s][w] && m_tag[s][w] == a[31:9]) return w;
    return -1;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] wv, input logic [1:0] bo, input logic [2:0] f);
    logic [31:0] v;
    if (f[1]) return wv;
    if (f[0]) begin
      v = (wv >> (int'(bo[1]) * 16)) & 32'hFFFF;
      if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    v = (wv >> (int'(bo) * 8)) & 32'hFF;
    if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] bo, input logic [2:0] f);
    logic [31:0] r = old;
    int lo, n;
    if (f[1])      begin lo = 0; n = 4; end
    else if (f[0]) begin lo = bo[1] ? 2 : 0; n = 2; end
    else           begin lo = int'(bo); n = 1; end
    for (int i = 0; i < n; i++) r[(lo+i)*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Per-cycle compare against the model
  logic [31:0] ca;
  int cs, cwd, chw, cvic, csel;
  bit c_inv, c_st, c_ed, c_ld;
  bit e_hit, e_valid, e_dirty, e_tknown;
  logic [22:0] e_tag;

  always @(posedge clk) begin
    if (!rst) begin
      ca    = bus.addr;
      cs    = int'(ca[8:4]);
      cwd   = int'(ca[3:2]);
      chw   = m_hitway(ca);
      cvic  = m_victim(cs);
      csel  = (chw >= 0) ? chw : cvic;
      e_hit    = (chw >= 0);
      e_valid  = m_valid[cs][csel];
      e_dirty  = m_dirty[cs][csel];
      e_tag    = m_tag[cs][csel];
      e_tknown = m_tknown[cs][csel];
      c_inv = bus.invalid;
      c_st  = bus.store && !c_inv;
      c_ed  = bus.edit && !c_inv && !bus.store;
      c_ld  = bus.load && !c_inv && !bus.store && !bus.edit;
      if (c_ld) begin
        if (e_hit) begin
          e_dout   = m_load(m_data[cs][chw][cwd], ca[1:0], bus.u_b_h_w);
          e_dknown = m_dknown[cs][chw][cwd];
        end
      end else begin
        e_dout   = m_data[cs][cvic][cwd];
        e_dknown = m_dknown[cs][cvic][cwd];
      end
      if (c_inv) begin
        for (int w = 0; w < W; w++) begin
          m_valid[cs][w] = 0;
          m_dirty[cs][w] = 0;
          m_order[cs][w] = w;
        end
      end else if (c_st) begin
        if (cwd == 0) begin
          m_fill = cvic;
          m_valid[cs][cvic]  = 1;
          m_dirty[cs][cvic]  = 0;
          m_tag[cs][cvic]    = ca[31:9];
          m_tknown[cs][cvic] = 1;
          m_touch(cs, cvic);
        end
        m_data[cs][m_fill][cwd]   = bus.din;
        m_dknown[cs][m_fill][cwd] = 1;
      end else if (c_ed && e_hit) begin
        m_data[cs][chw][cwd] = m_merge(m_data[cs][chw][cwd], bus.din, ca[1:0], bus.u_b_h_w);
        if (bus.u_b_h_w[1]) m_dknown[cs][chw][cwd] = 1;
        m_dirty[cs][chw] = 1;
        m_touch(cs, chw);
      end else if (c_ld && e_hit) begin
        m_touch(cs, chw);
      end
      #1;
      chk("hit", 32'(bus.hit), 32'(e_hit));
      chk("valid", 32'(bus.valid), 32'(e_valid));
      chk("dirty", 32'(bus.dirty), 32'(e_dirty));
      chk("victim_way", 32'(bus.victim_way), 32'(cvic));
      if (e_tknown) chk("tag", 32'(bus.tag), 32'(e_tag));
      if (e_dknown) chk("dout", bus.dout, e_dout);
    end
  end

  task automatic drive(input logic [31:0] a, input bit ld, input bit st, input bit ed,
                       input bit inv, input logic [2:0] f, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.load = ld; bus.store = st; bus.edit = ed;
    bus.invalid = inv; bus.u_b_h_w = f; bus.din = d;
    @(posedge clk);
    #2;
  endtask

  task automatic refill(input logic [31:0] base, input logic [31:0] d0);
    for (int i = 0; i < BW; i++)
      drive({base[31:4], 4'h0} | 32'(i * 4), 0, 1, 0, 0, 3'b010, d0 + 32'(i) * 32'h11);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bus.load = 0; bus.store = 0; bus.edit = 0; bus.invalid = 0;
    #1;
    chk("rst_hit", 32'(bus.hit), 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid_dirty", {30'b0, bus.valid, bus.dirty}, 0);
    chk("rst_tag_vic", {7'b0, bus.tag, bus.victim_way}, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] tg = 32'($urandom_range(1, 6));
    logic [31:0] st = 32'($urandom_range(0, 3));
    return (tg << 9) | (st << 4) | 32'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [31:0] a;
    int r;
    bit b0, b1, b2, b3;
    bus.addr = '0; bus.load = 0; bus.store = 0; bus.edit = 0;
    bus.invalid = 0; bus.u_b_h_w = 3'b010; bus.din = '0;
    do_reset();

    drive(32'h0000_0010, 1, 0, 0, 0, 3'b010, 0);
    chk("cold_hit", 32'(bus.hit), 0);
    chk("cold_valid", 32'(bus.valid), 0);
    chk("cold_victim", 32'(bus.victim_way), 0);

    refill(32'h0000_0200, 32'h11);
    drive(32'h0000_0204, 1, 0, 0, 0, 3'b010, 0);
    chk("lw_hit", 32'(bus.hit), 1);
    chk("lw_dout", bus.dout, 32'h22);

    drive(32'h0000_0204, 0, 0, 1, 0, 3'b010, 32'h8899_AABB);
    drive(32'h0000_0207, 1, 0, 0, 0, 3'b000, 0);
    chk("lb_dout", bus.dout, 32'hFFFF_FF88);
    drive(32'h0000_0207, 1, 0, 0, 0, 3'b100, 0);
    chk("lbu_dout", bus.dout, 32'h0000_0088);

    drive(32'h0000_0204, 0, 0, 1, 0, 3'b010, 32'h1234_5678);
    drive(32'h0000_0206, 0, 0, 1, 0, 3'b001, 32'h0000_BEEF);
    drive(32'h0000_0204, 1, 0, 0, 0, 3'b010, 0);
    chk("sh_dout", bus.dout, 32'hBEEF_5678);
    chk("sh_dirty", 32'(bus.dirty), 1);

    drive(32'h0000_0000, 0, 0, 0, 1, 3'b010, 0);
    for (int t = 2; t <= 5; t++) refill(32'(t) << 9, 32'(t) << 8);
    for (int t = 2; t <= 4; t++) drive(32'(t) << 9, 1, 0, 0, 0, 3'b010, 0);
    drive(32'h0000_0C00, 1, 0, 0, 0, 3'b010, 0);
    chk("lru_miss", 32'(bus.hit), 0);
    chk("lru_victim", 32'(bus.victim_way), 3);
    chk("lru_tag", 32'(bus.tag), 5);

    drive(32'h0000_0C00, 0, 1, 0, 1, 3'b010, 32'hDEAD_BEEF);
    drive(32'h0000_0C00, 1, 0, 0, 0, 3'b010, 0);
    chk("inv_hit", 32'(bus.hit), 0);
    chk("inv_valid", 32'(bus.valid), 0);
    chk("inv_victim", 32'(bus.victim_way), 0);

    drive(32'h0000_1000, 0, 1, 0, 0, 3'b010, 32'hAAAA_0000);
    drive(32'h0000_1004, 0, 1, 0, 0, 3'b010, 32'hAAAA_0001);
    do_reset();
    drive(32'h0000_1000, 1, 0, 0, 0, 3'b010, 0);
    chk("abort_hit", 32'(bus.hit), 0);
    chk("abort_valid", 32'(bus.valid), 0);

    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      a = rand_addr();
      if (r < 20) begin
        if (m_hitway(a) < 0) refill(a, $urandom);
        else drive(a, 1, 0, 0, 0, ftab[$urandom_range(0, 4)], 0);
      end else if (r < 55) begin
        drive(a, 1, 0, 0, 0, ftab[$urandom_range(0, 4)], 0);
      end else if (r < 75) begin
        drive(a, 0, 0, 1, 0, ftab[$urandom_range(0, 2)], $urandom);
      end else if (r < 78) begin
        drive(a, 0, 0, 0, 1, 3'b010, 0);
      end else if (r < 88) begin
        drive(a, 0, 0, 0, 0, 3'b010, 0);
      end else begin
        b0 = 1'($urandom); b1 = 1'($urandom); b2 = 1'($urandom); b3 = 1'($urandom);
        // stray fills stay off offset 0 so no tag is ever duplicated in a set
        if (b1 && a[3:2] == 2'b00) a[3:2] = 2'b01;
        drive(a, b0, b1, b2, b3, ftab[$urandom_range(0, 4)], $urandom);
      end
    end

    drive(32'h0, 0, 0, 0, 0, 3'b010, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
